// File: rtl/morse_key_classifier.sv
// Morse key classifier: synchronise and debounce the key, then emit DOT/DASH per mark, LETTER_END/WORD_END per gap, and a stuck-key level.
// Latency: PB edge to KEY_DB is 2+DEBOUNCE_CYC cycles, and events pulse one cycle after the deciding sample. There is no backpressure; pulses are fire-and-forget.
module morse_key_classifier #(
    parameter int unsigned CNT_W          = 28,
    parameter int unsigned DEBOUNCE_CYC   = 1000000,
    parameter int unsigned DASH_CYC       = 25000000,
    parameter int unsigned LETTER_GAP_CYC = 25000000,
    parameter int unsigned WORD_GAP_CYC   = 70000000,
    parameter int unsigned STUCK_CYC      = 200000000
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic PB,
    output logic KEY_DB,
    output logic DOT,
    output logic DASH,
    output logic LETTER_END,
    output logic WORD_END,
    output logic STUCK
);

    localparam logic [CNT_W-1:0] L_MAX     = '1;
    localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] L_DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] L_DASH    = CNT_W'(DASH_CYC);
    localparam logic [CNT_W-1:0] L_LETTER  = CNT_W'(LETTER_GAP_CYC);
    localparam logic [CNT_W-1:0] L_WORD    = CNT_W'(WORD_GAP_CYC);
    localparam logic [CNT_W-1:0] L_STUCK   = CNT_W'(STUCK_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_key_db;
    logic [CNT_W-1:0] r_db_cnt;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_dur;
    logic [CNT_W-1:0] w_dur_nxt;
    logic [CNT_W-1:0] w_dur_inc;
    logic             r_stuck;
    logic             w_stuck_nxt;
    logic             r_dot;
    logic             r_dash;
    logic             r_letter;
    logic             r_word;
    logic             w_dot_nxt;
    logic             w_dash_nxt;
    logic             w_letter_nxt;
    logic             w_word_nxt;

    // The debounce counter only runs while the synchronised level disagrees with KEY_DB.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_key_db <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= PB;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_key_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == L_DB_LAST) begin
                r_key_db <= r_sync2;
                r_db_cnt <= '0;
            end else if (r_db_cnt != L_MAX) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_dur_inc = (r_dur == L_MAX) ? r_dur : r_dur + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_dur_nxt    = r_dur;
        w_stuck_nxt  = r_stuck;
        w_dot_nxt    = 1'b0;
        w_dash_nxt   = 1'b0;
        w_letter_nxt = 1'b0;
        w_word_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_key_db) begin
                    w_state_nxt = S_MARK;
                    w_dur_nxt   = L_ONE;
                    w_stuck_nxt = (L_ONE >= L_STUCK);
                end
            end
            S_MARK: begin
                if (r_key_db) begin
                    w_dur_nxt = w_dur_inc;
                    if (w_dur_inc >= L_STUCK) begin
                        w_stuck_nxt = 1'b1;
                    end
                end else if (r_stuck) begin
                    // A stuck mark is dropped without a symbol and without gap events.
                    w_stuck_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                    w_dur_nxt   = '0;
                end else begin
                    w_dash_nxt  = (r_dur >= L_DASH);
                    w_dot_nxt   = (r_dur < L_DASH);
                    w_state_nxt = S_SPACE;
                    w_dur_nxt   = L_ONE;
                end
            end
            S_SPACE: begin
                if (r_key_db) begin
                    w_state_nxt = S_MARK;
                    w_dur_nxt   = L_ONE;
                end else begin
                    w_dur_nxt = w_dur_inc;
                    if (w_dur_inc == L_WORD) begin
                        w_word_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                        w_dur_nxt   = '0;
                    end else if (w_dur_inc == L_LETTER) begin
                        w_letter_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_dur_nxt   = '0;
                w_stuck_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= S_IDLE;
            r_dur    <= '0;
            r_stuck  <= 1'b0;
            r_dot    <= 1'b0;
            r_dash   <= 1'b0;
            r_letter <= 1'b0;
            r_word   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dur    <= w_dur_nxt;
            r_stuck  <= w_stuck_nxt;
            r_dot    <= w_dot_nxt;
            r_dash   <= w_dash_nxt;
            r_letter <= w_letter_nxt;
            r_word   <= w_word_nxt;
        end
    end

    assign KEY_DB     = r_key_db;
    assign DOT        = r_dot;
    assign DASH       = r_dash;
    assign LETTER_END = r_letter;
    assign WORD_END   = r_word;
    assign STUCK      = r_stuck;

endmodule

// File: doc/morse_key_classifier.md
Name: morse_key_classifier

Overview:
Parametrised successor to the single-button short/long press classifier. Takes the raw Morse key, synchronises and debounces it, and classifies each mark as DOT or DASH from its duration. It also classifies each space as intra-character, letter gap or word gap, and flags a stuck key. It feeds the symbol assembler / decoder downstream with one-cycle event pulses.

Parameters:
CNT_W, 28, width of the debounce and duration counters; both counters saturate at 2^CNT_W-1
DEBOUNCE_CYC, 1000000, cycles the synchronised input must be stable before KEY_DB follows it (10 ms at 100 MHz)
DASH_CYC, 25000000, a mark of at least this many cycles is a DASH; a shorter mark is a DOT
LETTER_GAP_CYC, 25000000, continuous low cycles after a mark that produce LETTER_END
WORD_GAP_CYC, 70000000, continuous low cycles after a mark that produce WORD_END
STUCK_CYC, 200000000, mark length at which the key is declared stuck
Constraints: 1 <= DEBOUNCE_CYC; DASH_CYC < STUCK_CYC; LETTER_GAP_CYC < WORD_GAP_CYC; every *_CYC <= 2^CNT_W-1.

Ports:
CLK  input  1  system clock; all logic on the rising edge
RESET_N  input  1  asynchronous, active-low reset
PB  input  1  raw key, asynchronous, active-high
KEY_DB  output  1  debounced key level
DOT  output  1  one-cycle pulse: short mark completed
DASH  output  1  one-cycle pulse: long mark completed
LETTER_END  output  1  one-cycle pulse: letter gap reached
WORD_END  output  1  one-cycle pulse: word gap reached
STUCK  output  1  level: current mark has reached STUCK_CYC

Behaviour:
- One clock; reset is asynchronous and active-low. While RESET_N=0, all outputs are 0, both synchroniser flops are 0, KEY_DB=0, counters are 0 and the state is IDLE. Reset asserted mid-mark or mid-gap discards everything in progress with no pulse.
- Synchroniser: two flops on PB give pb_s.
- Debounce: db_cnt clears whenever pb_s == KEY_DB and increments while they differ. When pb_s != KEY_DB for DEBOUNCE_CYC consecutive cycles, KEY_DB <= pb_s and db_cnt <= 0. Any glitch shorter than DEBOUNCE_CYC has no effect.
- Latency: a clean PB edge reaches KEY_DB in 2+DEBOUNCE_CYC cycles (+/-1 for async sampling).
- FSM states: IDLE, MARK, SPACE. dur is the saturating duration counter.
- IDLE:
  - KEY_DB=1 -> MARK, dur <= 1.
- MARK:
  - KEY_DB=1 -> dur <= dur+1 (saturating).
  - When dur reaches STUCK_CYC, STUCK <= 1 and holds while in MARK.
  - KEY_DB=0 with STUCK=0 -> let L = dur (cycles KEY_DB was high). Register DASH=1 if L >= DASH_CYC, else DOT=1, for exactly one cycle. Go to SPACE with dur <= 1.
  - KEY_DB=0 with STUCK=1 -> STUCK <= 0, no symbol, go to IDLE (no gap events).
- SPACE:
  - KEY_DB=0 -> dur <= dur+1.
  - After exactly LETTER_GAP_CYC continuous low cycles, LETTER_END pulses for one cycle and the FSM stays in SPACE.
  - After exactly WORD_GAP_CYC low cycles, WORD_END pulses for one cycle and the FSM goes to IDLE.
  - KEY_DB=1 -> MARK, dur <= 1, no pulse, whether or not LETTER_END has already fired.
- Pulses are registered outputs, asserted in the cycle after the deciding KEY_DB sample. At most one of DOT, DASH, LETTER_END, WORD_END is high in any cycle.
- LETTER_END and WORD_END fire only after a completed DOT or DASH. Idle time after reset or after a stuck release produces nothing.
- PB high at reset release is treated as a fresh press once debounced.
- Every mark produces exactly one symbol, or none if it was stuck.

Test Plan:
Sim parameters for all scenarios: CNT_W=8, DEBOUNCE_CYC=4, DASH_CYC=20, LETTER_GAP_CYC=20, WORD_GAP_CYC=50, STUCK_CYC=100.
1. Glitches: PB pulses of 1, 2 and 3 cycles, separated by 10 low cycles -> KEY_DB stays 0; no output ever asserts.
2. Dot then dash: PB high 10 cycles, low 8, high 30, then low -> DOT once, then DASH once. KEY_DB high periods measure exactly 10 and 30 cycles. No LETTER_END between the two marks.
3. Boundary: marks of KEY_DB length 19 and 20 -> DOT for 19, DASH for 20. A gap of 19 low cycles gives no LETTER_END; a gap of 20 gives LETTER_END exactly 1 cycle after the 20th low sample.
4. Word gap: a DOT followed by 60 low cycles -> LETTER_END at low-cycle 20 and WORD_END at low-cycle 50; FSM in IDLE; no further pulses during another 200 idle cycles.
5. Stuck key: PB held 150 cycles, then released -> STUCK rises after 100 KEY_DB-high cycles and falls on release. No DOT, DASH, LETTER_END or WORD_END.
6. Reset mid-mark: PB high, RESET_N pulled low at KEY_DB cycle 15 for 3 cycles while PB stays high -> outputs 0 immediately. After release, KEY_DB returns after 2+4 cycles and the subsequent 25-cycle mark yields a single DASH.
